// File: rtl/ldpc_pkg.sv
// Shared definitions for the layered QC-LDPC shift scheduler: default geometry,
// FSM state encoding and the null-block convention for the base-matrix mask.
package ldpc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int D_DEF      = 5;
  localparam int ROWS_DEF   = 4;
  localparam int COLS_DEF   = 8;
  localparam int IT_W_DEF   = 6;

  // A cleared mask bit marks a null (all-zero) circulant block.
  localparam logic NULL_BLK = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ROW,
    S_ITER_END,
    S_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ldpc_next_col.sv
// Combinational priority find: lowest set mask bit at or above ptr, plus a
// none-found flag. ptr carries one extra bit so "one past the last column" is legal.
module ldpc_next_col #(
  parameter int COLS  = 8,
  parameter int COL_W = 3
) (
  input  logic [COLS-1:0] mask,
  input  logic [COL_W:0]  ptr,
  output logic [COL_W-1:0] idx,
  output logic             none
);

  // Scan downward so the lowest qualifying column is the one left standing.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (mask[i] && ((COL_W + 1)'(i) >= ptr)) begin
        idx  = COL_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ldpc_shift_sched.sv
// Layered QC-LDPC decode scheduler: walks the non-null blocks of a configurable
// base matrix row by row, issuing (shift, col, row) beats to the cyclic-shift datapath.
module ldpc_shift_sched
  import ldpc_pkg::*;
#(
  parameter int data_w = DATA_W_DEF,
  parameter int D      = D_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int IT_W   = IT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [idx_w(ROWS)-1:0]   cfg_row,
  input  logic [idx_w(COLS)-1:0]   cfg_col,
  input  logic [data_w-1:0]        cfg_shift,
  input  logic                     cfg_nz,
  output logic                     cfg_err,
  input  logic                     start,
  input  logic                     abort,
  input  logic [IT_W-1:0]          max_iter,
  output logic                     busy,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [data_w-1:0]        shift,
  output logic [idx_w(COLS)-1:0]   col_addr,
  output logic [idx_w(ROWS)-1:0]   row_addr,
  output logic                     first_in_row,
  output logic                     last_in_row,
  input  logic                     row_ack,
  input  logic                     syn_ok,
  output logic [IT_W-1:0]          iter_cnt,
  output logic                     done,
  output logic                     converged
);

  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);
  localparam logic [data_w-1:0] D_LIM    = data_w'(D);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W:0]     col_ptr;
  logic               first_pend;
  logic [IT_W-1:0]    max_lat;
  logic [COLS-1:0]    mask [ROWS];
  logic [data_w-1:0]  shift_tab [ROWS][COLS];

  logic [COL_W-1:0]   nxt_idx;
  logic [COL_W-1:0]   la_idx;
  logic               nxt_none;
  logic               la_none;
  logic [COL_W:0]     la_ptr;
  logic [IT_W-1:0]    iter_next;

  assign la_ptr    = {1'b0, nxt_idx} + (COL_W + 1)'(1);
  assign iter_next = iter_cnt + IT_W'(1);

  ldpc_next_col #(.COLS(COLS), .COL_W(COL_W)) u_find (
    .mask (mask[row]),
    .ptr  (col_ptr),
    .idx  (nxt_idx),
    .none (nxt_none)
  );

  // Lookahead from the column being issued: its result is both the last_in_row
  // flag and the pointer for the following beat.
  ldpc_next_col #(.COLS(COLS), .COL_W(COL_W)) u_look (
    .mask (mask[row]),
    .ptr  (la_ptr),
    .idx  (la_idx),
    .none (la_none)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      row          <= '0;
      col_ptr      <= '0;
      first_pend   <= 1'b0;
      max_lat      <= '0;
      cfg_err      <= 1'b0;
      busy         <= 1'b0;
      issue_valid  <= 1'b0;
      shift        <= '0;
      col_addr     <= '0;
      row_addr     <= '0;
      first_in_row <= 1'b0;
      last_in_row  <= 1'b0;
      iter_cnt     <= '0;
      done         <= 1'b0;
      converged    <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        mask[r] <= {COLS{NULL_BLK}};
        for (int c = 0; c < COLS; c++) shift_tab[r][c] <= '0;
      end
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (state != S_IDLE || cfg_shift >= D_LIM) begin
          cfg_err <= 1'b1;
        end else begin
          shift_tab[cfg_row][cfg_col] <= cfg_shift;
          mask[cfg_row][cfg_col]      <= cfg_nz;
        end
      end

      if (busy && abort) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        issue_valid <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: if (start) begin
            max_lat    <= (max_iter == '0) ? IT_W'(1) : max_iter;
            iter_cnt   <= '0;
            row        <= '0;
            col_ptr    <= '0;
            first_pend <= 1'b1;
            converged  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
          S_ISSUE: begin
            if (!issue_valid && nxt_none) begin
              // Empty row: move on without issuing or waiting for an ack.
              col_ptr    <= '0;
              first_pend <= 1'b1;
              if (row == LAST_ROW) state <= S_ITER_END;
              else                 row   <= row + ROW_W'(1);
            end else if (issue_valid && issue_ready && last_in_row) begin
              issue_valid <= 1'b0;
              state       <= S_WAIT_ROW;
            end else if (!issue_valid || issue_ready) begin
              issue_valid  <= 1'b1;
              shift        <= shift_tab[row][nxt_idx];
              col_addr     <= nxt_idx;
              row_addr     <= row;
              first_in_row <= first_pend;
              last_in_row  <= la_none;
              first_pend   <= 1'b0;
              col_ptr      <= {1'b0, la_idx};
            end
          end
          S_WAIT_ROW: if (row_ack) begin
            col_ptr    <= '0;
            first_pend <= 1'b1;
            if (row == LAST_ROW) begin
              state <= S_ITER_END;
            end else begin
              row   <= row + ROW_W'(1);
              state <= S_ISSUE;
            end
          end
          S_ITER_END: begin
            iter_cnt <= iter_next;
            if (syn_ok || iter_next == max_lat) begin
              state     <= S_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              converged <= syn_ok;
            end else begin
              row        <= '0;
              col_ptr    <= '0;
              first_pend <= 1'b1;
              state      <= S_ISSUE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldpc_shift_sched.sv
// Self-checking bench for ldpc_shift_sched: a matrix-walk model predicts every
// accepted beat and the completion outcome; a monitor drives ready/row_ack and compares.
module tb_ldpc_shift_sched;

  typedef struct packed {
    logic [7:0] shift;
    logic [2:0] col;
    logic [1:0] row;
    logic       first;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_row;
  logic [2:0] cfg_col;
  logic [7:0] cfg_shift;
  logic       cfg_nz;
  logic       cfg_err;
  logic       start;
  logic       abort;
  logic [5:0] max_iter;
  logic       busy;
  logic       issue_valid;
  logic       issue_ready;
  logic [7:0] shift;
  logic [2:0] col_addr;
  logic [1:0] row_addr;
  logic       first_in_row;
  logic       last_in_row;
  logic       row_ack;
  logic       syn_ok;
  logic [5:0] iter_cnt;
  logic       done;
  logic       converged;

  ldpc_shift_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_shift(cfg_shift), .cfg_nz(cfg_nz), .cfg_err(cfg_err), .start(start),
    .abort(abort), .max_iter(max_iter), .busy(busy), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .shift(shift), .col_addr(col_addr), .row_addr(row_addr),
    .first_in_row(first_in_row), .last_in_row(last_in_row), .row_ack(row_ack),
    .syn_ok(syn_ok), .iter_cnt(iter_cnt), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  int    m_shift [4][8];
  bit    m_mask  [4][8];

  int         cyc = 0;
  int         ack_cnt = 0;
  int         ack_cyc = 0;
  int         ack_row = -1;
  int         stall_left = 0;
  bit         stall_armed = 0;
  bit         hold_pending = 0;
  bit         gap_en = 1;
  beat_t      held;
  logic [5:0] prev_iter = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Model: every iteration visits rows in order, non-null columns ascending.
  task automatic queue_iters(input int n);
    int    cols[$];
    beat_t b;
    for (int it = 0; it < n; it++)
      for (int r = 0; r < 4; r++) begin
        cols.delete();
        for (int c = 0; c < 8; c++) if (m_mask[r][c]) cols.push_back(c);
        foreach (cols[i]) begin
          b.shift = 8'(m_shift[r][cols[i]]);
          b.col   = 3'(cols[i]);
          b.row   = 2'(r);
          b.first = (i == 0);
          b.last  = (i == cols.size() - 1);
          exp_q.push_back(b);
        end
      end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        m_shift[r][c] = 0;
        m_mask[r][c]  = 0;
      end
  endtask

  task automatic write_cfg(input int r, input int c, input int s, input bit nz, input bit while_busy);
    bit exp_err;
    exp_err   = (s >= 5) || while_busy;
    cfg_we    = 1'b1;
    cfg_row   = 2'(r);
    cfg_col   = 3'(c);
    cfg_shift = 8'(s);
    cfg_nz    = nz;
    tick();
    cfg_we = 1'b0;
    check_output("cfg_err_pulse", 32'(cfg_err), 32'(exp_err));
    if (!exp_err) begin
      m_shift[r][c] = s;
      m_mask[r][c]  = nz;
    end
    tick();
    check_output("cfg_err_clear", 32'(cfg_err), 32'd0);
  endtask

  task automatic apply_stimulus(input int mx, input bit syn);
    max_iter = 6'(mx);
    syn_ok   = syn;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_output("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int exp_iters, input bit exp_conv);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check_output("done_pulse", 32'(done), 32'd1);
    if (done !== 1'b1) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    check_output("busy_at_done", 32'(busy), 32'd0);
    check_output("converged", 32'(converged), 32'(exp_conv));
    check_output("iter_cnt", 32'(iter_cnt), 32'(exp_iters));
    check_output("beats_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    check_output("done_one_cycle", 32'(done), 32'd0);
    check_output("converged_held", 32'(converged), 32'(exp_conv));
  endtask

  // Monitor: samples on the falling edge, drives ready/row_ack for the next rising edge.
  initial begin
    beat_t cur;
    beat_t e;
    issue_ready = 1'b1;
    row_ack     = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {shift, col_addr, row_addr, first_in_row, last_in_row};
      if (hold_pending) begin
        check_output("stall_valid_held", 32'(issue_valid), 32'd1);
        check_output("stall_beat_stable", 32'(cur), 32'(held));
        hold_pending = 0;
      end
      row_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          row_ack = 1'b1;
          ack_cyc = cyc;
          ack_row = int'(row_addr);
        end
      end
      issue_ready = 1'b1;
      if (stall_left > 0) begin
        issue_ready = 1'b0;
        stall_left--;
      end else if (stall_armed && issue_valid && row_addr == 2'd0 && col_addr == 3'd4) begin
        stall_armed = 0;
        issue_ready = 1'b0;
        stall_left  = 2;
      end
      if (issue_valid && !issue_ready) begin
        hold_pending = 1;
        held = cur;
      end
      if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          check_output("extra_beat", 32'(cur), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check_output("beat", 32'(cur), 32'(e));
        end
        if (last_in_row) ack_cnt = 2;
      end
      if (gap_en && iter_cnt != prev_iter && iter_cnt != 6'd0 && ack_row == 1)
        check_output("iter_end_gap_le4", 32'((cyc - ack_cyc) <= 4), 32'd1);
      prev_iter = iter_cnt;
    end
  end

  initial begin
    int n;
    rst = 1'b0; cfg_we = 1'b0; cfg_row = '0; cfg_col = '0; cfg_shift = '0; cfg_nz = 1'b0;
    start = 1'b0; abort = 1'b0; max_iter = '0; syn_ok = 1'b0;
    clear_model();
    repeat (3) tick();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_valid", 32'(issue_valid), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_converged", 32'(converged), 32'd0);
    check_output("rst_iter_cnt", 32'(iter_cnt), 32'd0);
    check_output("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_output("rst_beat", 32'({shift, col_addr, row_addr, first_in_row, last_in_row}), 32'd0);
    rst = 1'b1;
    tick();

    // Scenario 1: two iterations, never converging
    write_cfg(0, 1, 3, 1'b1, 1'b0);
    write_cfg(0, 4, 0, 1'b1, 1'b0);
    write_cfg(1, 2, 4, 1'b1, 1'b0);
    queue_iters(2);
    check_output("model_size", 32'(exp_q.size()), 32'd6);
    check_output("model_b0", 32'(exp_q[0]), 32'(beat_t'{8'd3, 3'd1, 2'd0, 1'b1, 1'b0}));
    check_output("model_b1", 32'(exp_q[1]), 32'(beat_t'{8'd0, 3'd4, 2'd0, 1'b0, 1'b1}));
    check_output("model_b2", 32'(exp_q[2]), 32'(beat_t'{8'd4, 3'd2, 2'd1, 1'b1, 1'b1}));
    apply_stimulus(2, 1'b0);
    wait_done(2, 1'b0);

    // Scenario 2: syndrome satisfied at the first iteration end
    queue_iters(1);
    apply_stimulus(2, 1'b1);
    wait_done(1, 1'b1);
    syn_ok = 1'b0;

    // Scenario 3: back-pressure on beat (0,4)
    stall_armed = 1;
    queue_iters(1);
    apply_stimulus(1, 1'b0);
    wait_done(1, 1'b0);
    check_output("stall_happened", 32'(stall_armed), 32'd0);

    // Scenario 4: rejected writes leave the table untouched
    write_cfg(2, 0, 5, 1'b1, 1'b0);
    queue_iters(1);
    apply_stimulus(1, 1'b0);
    write_cfg(3, 5, 1, 1'b1, 1'b1);
    wait_done(1, 1'b0);
    queue_iters(1);
    apply_stimulus(1, 1'b0);
    wait_done(1, 1'b0);

    // max_iter of zero runs a single iteration
    queue_iters(1);
    apply_stimulus(0, 1'b0);
    wait_done(1, 1'b0);

    // Scenario 6: abort while waiting on row 0's ack
    queue_iters(2);
    apply_stimulus(2, 1'b0);
    n = 0;
    while (exp_q.size() > 4 && n < 200) begin
      tick();
      n++;
    end
    check_output("abort_reached_row_end", 32'(exp_q.size()), 32'd4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_valid", 32'(issue_valid), 32'd0);
    check_output("abort_iter_cnt", 32'(iter_cnt), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) n++;
      tick();
    end
    check_output("abort_no_done", 32'(n), 32'd0);
    exp_q.delete();
    queue_iters(2);
    apply_stimulus(2, 1'b0);
    wait_done(2, 1'b0);

    // Reset mid-decode drops the table; an empty matrix still completes
    queue_iters(2);
    apply_stimulus(2, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_valid", 32'(issue_valid), 32'd0);
    check_output("midrst_iter_cnt", 32'(iter_cnt), 32'd0);
    exp_q.delete();
    hold_pending = 0;
    rst = 1'b1;
    repeat (3) tick();
    clear_model();
    gap_en = 0;
    apply_stimulus(1, 1'b0);
    wait_done(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_shift_sched.md
Name: ldpc_shift_sched

Overview:
- Layered QC-LDPC decode scheduler driving the cyclic-shift datapath between variable and check memories.
- Holds a configurable base matrix: a shift value per (row, col) block plus a non-null mask.
- Per iteration, walks rows in order and, within each row, the non-null columns in ascending order, issuing one (shift, col, row) beat per block.
- Waits for the datapath's row completion, then decides continue/converge/stop on syndrome status and the iteration limit.

Parameters:
- data_w, 8, width of shift value and of datapath shift port
- D, 5, lifting (circulant) size; legal shift range 0..D-1
- ROWS, 4, base-matrix rows (layers)
- COLS, 8, base-matrix columns
- IT_W, 6, iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_row  in  clog2(ROWS)  write row index
- cfg_col  in  clog2(COLS)  write column index
- cfg_shift  in  data_w  shift value to store
- cfg_nz  in  1  1 = non-null block, 0 = null (clears mask bit)
- cfg_err  out  1  one-cycle pulse: write rejected
- start  in  1  begin decode (pulse)
- abort  in  1  synchronous abort (pulse)
- max_iter  in  IT_W  iteration limit, sampled at start; 0 treated as 1
- busy  out  1  high from start acceptance until done/abort
- issue_valid  out  1  beat valid
- issue_ready  in  1  datapath accepts beat
- shift  out  data_w  circulant shift of current beat
- col_addr  out  clog2(COLS)  column of current beat
- row_addr  out  clog2(ROWS)  row of current beat
- first_in_row  out  1  beat is first non-null of row
- last_in_row  out  1  beat is last non-null of row
- row_ack  in  1  datapath finished current row's check update
- syn_ok  in  1  all parity checks satisfied; sampled at iteration end
- iter_cnt  out  IT_W  completed iterations
- done  out  1  one-cycle completion pulse
- converged  out  1  valid with done; held until next start

Behaviour:
- Reset: all outputs 0, all mask bits 0, shift table 0, FSM IDLE.
- Config: write accepted only in IDLE; a write with cfg_shift >= D, or any write while busy, is not stored and pulses cfg_err the next cycle. Data is visible to a start issued the cycle after the write.
- States: IDLE, ISSUE, WAIT_ROW, ITER_END, DONE.
- IDLE: start latches max_iter, clears iter_cnt, row=0, and moves to ISSUE the next cycle. start while busy is ignored.
- ISSUE: next column = lowest set mask bit at or above the current column pointer (combinational priority find). Beat outputs are registered; issue_valid rises the cycle after entering ISSUE. Outputs hold stable while valid && !ready. On a handshake, advance to the next set bit; after last_in_row, go to WAIT_ROW.
- Empty row (mask all zero): skipped in one cycle; no beat and no row_ack wait.
- first_in_row and last_in_row are both 1 for a single-entry row.
- WAIT_ROW: issue_valid=0. On row_ack: row+1, or ITER_END after row ROWS-1. row_ack outside WAIT_ROW is ignored.
- ITER_END (1 cycle): iter_cnt+1, then:
  - syn_ok=1 -> DONE, converged=1;
  - else iter_cnt == max_iter -> DONE, converged=0;
  - else row=0, ISSUE.
- Whole matrix empty: each iteration completes with no beats; the normal decision rules apply.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- abort in any busy state: next cycle IDLE, issue_valid=0, busy=0, no done pulse; iter_cnt holds its value. abort in IDLE has no effect. abort has priority over all other events.
- Reset mid-decode: immediate return to the reset state; the table is lost.
- Throughput: one beat per cycle while issue_ready=1 within a row.

Decomposition:
- Shared package ldpc_pkg: state encoding; index widths (clog2 of ROWS/COLS); null-entry convention (mask bit 0).
- Sub-module ldpc_next_col: combinational find of the next set mask bit at or above a pointer, with a none-found flag. Reused for last_in_row detection via a lookahead from col+1.

Test Plan:
1. Reset, then write (r0,c1,s=3), (r0,c4,s=0), (r1,c2,s=4); max_iter=2; ready always 1; syn_ok=0; row_ack 2 cycles after each last beat.
   -> beats (0,1,3,f), (0,4,0,l), (1,2,4,f+l); repeated for 2 iterations; done with converged=0, iter_cnt=2.
2. Same table, syn_ok=1 at the first ITER_END -> done after 1 iteration, converged=1, iter_cnt=1.
3. Hold issue_ready=0 for 3 cycles on beat (0,4).
   -> shift/col/row/flags stable and issue_valid held; no beat skipped or duplicated.
4. cfg_shift=5 with D=5, and a write issued while busy -> cfg_err pulse each time; table unchanged, verified by the next decode's beats.
5. Rows 2 and 3 empty, ROWS=4 -> no beats and no row_ack waits for rows 2-3; ITER_END follows row1's row_ack by at most 3 cycles.
6. abort during WAIT_ROW of iteration 1 -> busy=0 next cycle, no done; a subsequent start reproduces scenario 1's beat sequence exactly.
